// File: rtl/core_mem_responder_if.sv
// Shared backing-memory bus between the responder (master) and the SDRAM controller (slave).
// bk_req rises with a complete request and holds it stable until the single-cycle bk_ack;
// bk_rdata is only meaningful in the bk_ack cycle of a read.
interface core_mem_responder_if;
    logic        bk_req;
    logic        bk_we;
    logic        bk_refresh;
    logic [24:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        bk_ack;
    logic [7:0]  bk_rdata;

    modport master (
        output bk_req, bk_we, bk_refresh, bk_addr, bk_wdata,
        input  bk_ack, bk_rdata
    );

    modport slave (
        input  bk_req, bk_we, bk_refresh, bk_addr, bk_wdata,
        output bk_ack, bk_rdata
    );
endinterface

// File: rtl/core_mem_responder.sv
// Captures CPU/PPU memory strobes and refresh requests into one-deep slots and
// arbitrates them onto the shared backing bus (refresh-urgent > PPU > CPU > refresh).
module core_mem_responder #(
    parameter logic [24:0] PPU_BASE    = 25'h0800000,
    parameter int          REFRESH_MAX = 64
) (
    input  logic        core_cpu_clk,
    input  logic        core_cpu_reset_n,
    input  logic [24:0] core_cpu_sdraminterface_memaddr,
    input  logic        core_cpu_sdraminterface_memread,
    input  logic        core_cpu_sdraminterface_memwrite,
    input  logic [7:0]  core_cpu_sdraminterface_memdout,
    output logic [7:0]  core_cpu_sdraminterface_memdin,
    input  logic [21:0] core_cpu_ppuinterface_ppumemaddr,
    input  logic        core_cpu_ppuinterface_ppumemread,
    input  logic        core_cpu_ppuinterface_ppumemwrite,
    input  logic [7:0]  core_cpu_ppuinterface_ppumemdout,
    output logic [7:0]  core_cpu_ppuinterface_ppumemdin,
    input  logic        core_cpu_sdraminterface_refresh,
    core_mem_responder_if.master bk,
    output logic        cpu_busy,
    output logic        ppu_busy,
    output logic        overrun,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, GAP = 2'd2} state_t;
    typedef enum logic [1:0] {SEL_CPU = 2'd0, SEL_PPU = 2'd1, SEL_REF = 2'd2} sel_t;

    localparam int AGE_W = $clog2(REFRESH_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(REFRESH_MAX);

    state_t state, state_nx;
    sel_t   sel;

    logic        cpu_v, cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ppu_v, ppu_we;
    logic [24:0] ppu_addr;
    logic [7:0]  ppu_wdata;

    logic             ref_pending;
    logic [AGE_W-1:0] ref_age;
    logic             ref_urgent;

    logic grant_cpu, grant_ppu, grant_ref;
    logic cpu_stb, ppu_stb;
    logic [24:0] ppu_full_addr;

    logic        req_we, req_refresh;
    logic [24:0] req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  cpu_din, ppu_din;

    assign cpu_stb = core_cpu_sdraminterface_memread | core_cpu_sdraminterface_memwrite;
    assign ppu_stb = core_cpu_ppuinterface_ppumemread | core_cpu_ppuinterface_ppumemwrite;
    assign ppu_full_addr = PPU_BASE + {3'b000, core_cpu_ppuinterface_ppumemaddr};
    assign ref_urgent = ref_pending && (ref_age >= AGE_MAX);

    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_ppu = 1'b0;
        grant_ref = 1'b0;
        unique case (state)
            IDLE: begin
                if (ref_urgent)       grant_ref = 1'b1;
                else if (ppu_v)       grant_ppu = 1'b1;
                else if (cpu_v)       grant_cpu = 1'b1;
                else if (ref_pending) grant_ref = 1'b1;
                if (grant_cpu || grant_ppu || grant_ref) state_nx = ACCESS;
            end
            ACCESS: if (bk.bk_ack) state_nx = GAP;
            GAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge core_cpu_clk or negedge core_cpu_reset_n) begin
        if (!core_cpu_reset_n) state <= IDLE;
        else                   state <= state_nx;
    end

    // A strobe on the grant edge reloads the slot; it only counts as an overrun
    // when it displaces an access that was not issued on that same edge.
    always_ff @(posedge core_cpu_clk or negedge core_cpu_reset_n) begin
        if (!core_cpu_reset_n) begin
            cpu_v       <= 1'b0;
            cpu_we      <= 1'b0;
            cpu_addr    <= '0;
            cpu_wdata   <= '0;
            ppu_v       <= 1'b0;
            ppu_we      <= 1'b0;
            ppu_addr    <= '0;
            ppu_wdata   <= '0;
            overrun     <= 1'b0;
            ref_pending <= 1'b0;
            ref_age     <= '0;
        end else begin
            if (cpu_stb) begin
                cpu_v     <= 1'b1;
                cpu_we    <= core_cpu_sdraminterface_memwrite;
                cpu_addr  <= core_cpu_sdraminterface_memaddr;
                cpu_wdata <= core_cpu_sdraminterface_memdout;
            end else if (grant_cpu) begin
                cpu_v <= 1'b0;
            end

            if (ppu_stb) begin
                ppu_v     <= 1'b1;
                ppu_we    <= core_cpu_ppuinterface_ppumemwrite;
                ppu_addr  <= ppu_full_addr;
                ppu_wdata <= core_cpu_ppuinterface_ppumemdout;
            end else if (grant_ppu) begin
                ppu_v <= 1'b0;
            end

            if ((cpu_stb && cpu_v && !grant_cpu) || (ppu_stb && ppu_v && !grant_ppu))
                overrun <= 1'b1;

            if (core_cpu_sdraminterface_refresh) begin
                ref_pending <= 1'b1;
                ref_age     <= '0;
            end else if (grant_ref) begin
                ref_pending <= 1'b0;
                ref_age     <= '0;
            end else if (ref_pending && ref_age != AGE_MAX) begin
                ref_age <= ref_age + 1'b1;
            end
        end
    end

    always_ff @(posedge core_cpu_clk or negedge core_cpu_reset_n) begin
        if (!core_cpu_reset_n) begin
            sel         <= SEL_CPU;
            req_we      <= 1'b0;
            req_refresh <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
        end else if (grant_ppu) begin
            sel         <= SEL_PPU;
            req_we      <= ppu_we;
            req_refresh <= 1'b0;
            req_addr    <= ppu_addr;
            req_wdata   <= ppu_wdata;
        end else if (grant_cpu) begin
            sel         <= SEL_CPU;
            req_we      <= cpu_we;
            req_refresh <= 1'b0;
            req_addr    <= cpu_addr;
            req_wdata   <= cpu_wdata;
        end else if (grant_ref) begin
            sel         <= SEL_REF;
            req_we      <= 1'b0;
            req_refresh <= 1'b1;
            req_addr    <= '0;
            req_wdata   <= '0;
        end
    end

    always_ff @(posedge core_cpu_clk or negedge core_cpu_reset_n) begin
        if (!core_cpu_reset_n) begin
            cpu_din <= 8'h00;
            ppu_din <= 8'h00;
        end else if (state == ACCESS && bk.bk_ack && !req_we && !req_refresh) begin
            if (sel == SEL_CPU) cpu_din <= bk.bk_rdata;
            if (sel == SEL_PPU) ppu_din <= bk.bk_rdata;
        end
    end

    assign bk.bk_req     = (state == ACCESS);
    assign bk.bk_we      = req_we;
    assign bk.bk_refresh = req_refresh;
    assign bk.bk_addr    = req_addr;
    assign bk.bk_wdata   = req_wdata;

    assign core_cpu_sdraminterface_memdin  = cpu_din;
    assign core_cpu_ppuinterface_ppumemdin = ppu_din;
    assign cpu_busy  = cpu_v || (state == ACCESS && sel == SEL_CPU);
    assign ppu_busy  = ppu_v || (state == ACCESS && sel == SEL_PPU);
    assign fsm_state = state;

endmodule
